// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit: next-PC select codes,
// run/halt state and the target alignment rule.
package pc_unit_pkg;

    localparam logic [1:0] SEL_SEQ  = 2'b00;
    localparam logic [1:0] SEL_JAL  = 2'b01;
    localparam logic [1:0] SEL_JALR = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    // Bit 0 of a legal target is always clear, so only bit 1 decides alignment.
    function automatic logic target_misaligned(input logic addr_bit1, input bit c_ext);
        return !c_ext && addr_bit1;
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program-counter unit: architectural PC register, next-PC selection,
// stall, halt-address detection, misaligned-target trap and retire counter.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | PC advances on every non-stalled edge (sequential or redirect)
//   HALT  | sequential fetch reached HALT_PC; everything frozen until rst
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              HALT_EN  = 1'b1,
    parameter logic [XLEN-1:0] HALT_PC  = XLEN'(32'h0000_006c),
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
    parameter bit              C_EXT    = 1'b0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       sel,
    input  logic             branch_taken,
    input  logic             trap_ret,
    input  logic [XLEN-1:0]  offset,
    input  logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  next_pc,
    output logic [XLEN-1:0]  epc,
    output logic             trap,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [XLEN-1:0] ILEN = XLEN'(4);

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   epc_q;
    logic              trap_q;
    logic [CNT_W-1:0]  instret_q;

    logic [XLEN-1:0]   pc_d;
    logic [CNT_W-1:0]  instret_d;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   jalr_sum;
    logic              redirect;
    logic              sequential;
    logic              take_trap;
    logic              halt_hit;

    assign jalr_sum = rs1_data + offset;

    always_comb begin
        target     = pc_q + ILEN;
        redirect   = 1'b0;
        sequential = 1'b0;
        if (trap_ret) begin
            target   = epc_q;
            redirect = 1'b1;
        end else if (sel == SEL_JAL) begin
            target   = pc_q + offset;
            redirect = 1'b1;
        end else if (sel == SEL_JALR) begin
            target   = {jalr_sum[XLEN-1:1], 1'b0};
            redirect = 1'b1;
        end else if (branch_taken) begin
            target   = pc_q + offset;
            redirect = 1'b1;
        end else begin
            sequential = 1'b1;
        end
    end

    // Only redirects can land misaligned; pc+4 from an aligned pc never does.
    assign take_trap = (state_q == RUN) && redirect && target_misaligned(target[1], C_EXT);
    assign halt_hit  = (state_q == RUN) && HALT_EN && sequential && (pc_q == HALT_PC);

    always_comb begin
        pc_d = target;
        if (state_q == HALT || halt_hit) begin
            pc_d = pc_q;
        end else if (take_trap) begin
            pc_d = TRAP_VEC;
        end
    end

    assign instret_d = instret_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            trap_q <= 1'b0;
            if (!stall) begin
                case (state_q)
                    RUN: begin
                        pc_q <= pc_d;
                        if (take_trap) begin
                            epc_q  <= pc_q;
                            trap_q <= 1'b1;
                        end else begin
                            instret_q <= instret_d;
                            if (halt_hit) begin
                                state_q <= HALT;
                            end
                        end
                    end
                    HALT: begin
                        state_q <= HALT;
                    end
                    default: begin
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

    assign pc      = pc_q;
    assign next_pc = pc_d;
    assign epc     = epc_q;
    assign trap    = trap_q;
    assign halted  = (state_q == HALT);
    assign instret = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: each task builds a row table of stimulus with
// hand-derived expected state, queues the expectation, and checks after the edge.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  sel;
    logic        branch_taken;
    logic        trap_ret;
    logic [31:0] offset;
    logic [31:0] rs1_data;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] epc;
    logic        trap;
    logic        halted;
    logic [31:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    typedef struct packed {
        logic        rst;
        logic        st;
        logic [1:0]  sel;
        logic        bt;
        logic        tr;
        logic [31:0] off;
        logic [31:0] rs1;
        logic        chk_npc;
        logic [31:0] npc;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [31:0] epc;
        logic        trap;
        logic        halted;
    } row_t;

    row_t exp_q[$];

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .sel          (sel),
        .branch_taken (branch_taken),
        .trap_ret     (trap_ret),
        .offset       (offset),
        .rs1_data     (rs1_data),
        .pc           (pc),
        .next_pc      (next_pc),
        .epc          (epc),
        .trap         (trap),
        .halted       (halted),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic row_t mk(logic r, logic st, logic [1:0] s, logic bt, logic tr,
                                logic [31:0] off, logic [31:0] r1, logic cn, logic [31:0] npc,
                                logic [31:0] p, logic [31:0] c, logic [31:0] ep, logic t, logic h);
        row_t x;
        x.rst = r;   x.st = st;   x.sel = s;    x.bt = bt;  x.tr = tr;
        x.off = off; x.rs1 = r1;  x.chk_npc = cn; x.npc = npc;
        x.pc = p;    x.cnt = c;   x.epc = ep;   x.trap = t; x.halted = h;
        return x;
    endfunction

    task automatic apply(input row_t r);
        rst          = r.rst;
        stall        = r.st;
        sel          = r.sel;
        branch_taken = r.bt;
        trap_ret     = r.tr;
        offset       = r.off;
        rs1_data     = r.rs1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ,N,N,32'h0,32'h0, N,32'h0, 32'h0,32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0,32'h0, Y,32'h4, 32'h4,32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0,32'h0, Y,32'h8, 32'h8,32'd2,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0,32'h0, Y,32'hc, 32'hc,32'd3,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL reset[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL reset[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_jumps();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ, N,N,32'h0,      32'h0,     N,32'h0,   32'h0,  32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL, N,N,32'h20,     32'h0,     Y,32'h20,  32'h20, 32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL, N,N,32'h40,     32'h0,     Y,32'h60,  32'h60, 32'd2,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JALR,N,N,32'h0,      32'h101,   Y,32'h100, 32'h100,32'd3,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_RSVD,N,N,32'h0,      32'h0,     Y,32'h104, 32'h104,32'd4,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JALR,Y,N,32'h8,      32'h200,   Y,32'h208, 32'h208,32'd5,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ, Y,N,32'hFFFF_FFF8,32'h0,   Y,32'h200, 32'h200,32'd6,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_RSVD,Y,N,32'h30,     32'h0,     Y,32'h230, 32'h230,32'd7,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JALR,N,N,32'h5,      32'h3fc,   Y,32'h400, 32'h400,32'd8,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL jumps[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL jumps[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_trap();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ, N,N,32'h0, 32'h0,  N,32'h0,   32'h0,  32'd0,32'h0, N,N));
        rows.push_back(mk(N,N,SEL_JAL, N,N,32'h10,32'h0,  Y,32'h10,  32'h10, 32'd1,32'h0, N,N));
        rows.push_back(mk(N,N,SEL_JAL, N,N,32'h6, 32'h0,  Y,32'h100, 32'h100,32'd1,32'h10,Y,N));
        rows.push_back(mk(N,N,SEL_SEQ, N,Y,32'h0, 32'h0,  Y,32'h10,  32'h10, 32'd2,32'h10,N,N));
        rows.push_back(mk(N,N,SEL_SEQ, N,N,32'h0, 32'h0,  Y,32'h14,  32'h14, 32'd3,32'h10,N,N));
        rows.push_back(mk(N,N,SEL_JALR,N,N,32'h0, 32'h22, Y,32'h100, 32'h100,32'd3,32'h14,Y,N));
        rows.push_back(mk(N,N,SEL_JAL, N,Y,32'h6, 32'h0,  Y,32'h14,  32'h14, 32'd4,32'h14,N,N));
        rows.push_back(mk(N,Y,SEL_JAL, N,N,32'h2, 32'h0,  Y,32'h100, 32'h14, 32'd4,32'h14,N,N));
        rows.push_back(mk(N,N,SEL_SEQ, Y,N,32'ha, 32'h0,  Y,32'h100, 32'h100,32'd4,32'h14,Y,N));
        rows.push_back(mk(Y,N,SEL_SEQ, N,N,32'h0, 32'h0,  N,32'h0,   32'h0,  32'd0,32'h0, N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL trap[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL trap[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_halt();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ,N,N,32'h0, 32'h0,N,32'h0, 32'h0, 32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL,N,N,32'h60,32'h0,Y,32'h60,32'h60,32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0, 32'h0,Y,32'h64,32'h64,32'd2,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0, 32'h0,Y,32'h68,32'h68,32'd3,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0, 32'h0,Y,32'h6c,32'h6c,32'd4,32'h0,N,N));
        rows.push_back(mk(N,Y,SEL_SEQ,N,N,32'h0, 32'h0,Y,32'h6c,32'h6c,32'd4,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0, 32'h0,Y,32'h6c,32'h6c,32'd5,32'h0,N,Y));
        for (int k = 0; k < 10; k++) begin
            rows.push_back(mk(N,N,SEL_JAL,Y,Y,32'h10,32'h0,Y,32'h6c,32'h6c,32'd5,32'h0,N,Y));
        end
        rows.push_back(mk(Y,N,SEL_SEQ,N,N,32'h0, 32'h0,N,32'h0, 32'h0, 32'd0,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL halt[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL halt[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_branch_at_halt_pc();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ,N,N,32'h0,        32'h0,N,32'h0, 32'h0, 32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL,N,N,32'h6c,       32'h0,Y,32'h6c,32'h6c,32'd1,32'h0,N,N));
        rows.push_back(mk(N,Y,SEL_SEQ,Y,N,32'hFFFF_FFF8,32'h0,Y,32'h64,32'h6c,32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,Y,N,32'hFFFF_FFF8,32'h0,Y,32'h64,32'h64,32'd2,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL,N,N,32'h8,        32'h0,Y,32'h6c,32'h6c,32'd3,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL,N,N,32'h0,        32'h0,Y,32'h6c,32'h6c,32'd4,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL branch_halt_pc[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL branch_halt_pc[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ,N,N,32'h0,32'h0,N,32'h0,32'h0,32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0,32'h0,Y,32'h4,32'h4,32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0,32'h0,Y,32'h8,32'h8,32'd2,32'h0,N,N));
        for (int k = 0; k < 4; k++) begin
            rows.push_back(mk(N,Y,SEL_SEQ,N,N,32'h0,32'h0,Y,32'hc,32'h8,32'd2,32'h0,N,N));
        end
        rows.push_back(mk(Y,Y,SEL_SEQ,N,N,32'h0,32'h0,N,32'h0,32'h0,32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,N,32'h0,32'h0,Y,32'h4,32'h4,32'd1,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL stall[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL stall[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ, N,N,32'h0,        32'h0,        N,32'h0,        32'h0,        32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JALR,N,N,32'h0,        32'hFFFF_FFFC,Y,32'hFFFF_FFFC,32'hFFFF_FFFC,32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ, N,N,32'h0,        32'h0,        Y,32'h0,        32'h0,        32'd2,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL, N,N,32'hFFFF_FFFC,32'h0,        Y,32'hFFFF_FFFC,32'hFFFF_FFFC,32'd3,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JALR,N,N,32'h20,       32'hFFFF_FFF0,Y,32'h10,       32'h10,       32'd4,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL wrap[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        row_t e;
        rows.push_back(mk(Y,N,SEL_SEQ,N,N,32'h0, 32'h0,N,32'h0,  32'h0,  32'd0,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_JAL,N,N,32'h2, 32'h0,Y,32'h100,32'h100,32'd0,32'h0,Y,N));
        rows.push_back(mk(N,N,SEL_JAL,N,N,32'h10,32'h0,Y,32'h110,32'h110,32'd1,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,Y,32'h0, 32'h0,Y,32'h0,  32'h0,  32'd2,32'h0,N,N));
        rows.push_back(mk(N,N,SEL_SEQ,N,Y,32'h0, 32'h0,Y,32'h0,  32'h0,  32'd3,32'h0,N,N));
        foreach (rows[i]) begin
            apply(rows[i]);
            exp_q.push_back(rows[i]);
            #1;
            if (rows[i].chk_npc) begin
                n_tests++;
                if (next_pc !== rows[i].npc) begin
                    n_fail++;
                    $display("FAIL back_to_back[%0d] next_pc: got %h want %h", i, next_pc, rows[i].npc);
                end
            end
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if (pc !== e.pc || instret !== e.cnt || epc !== e.epc || trap !== e.trap || halted !== e.halted) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got pc=%h instret=%0d epc=%h trap=%b halted=%b, want pc=%h instret=%0d epc=%h trap=%b halted=%b",
                         i, pc, instret, epc, trap, halted, e.pc, e.cnt, e.epc, e.trap, e.halted);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        sel          = SEL_SEQ;
        branch_taken = 1'b0;
        trap_ret     = 1'b0;
        offset       = 32'h0;
        rs1_data     = 32'h0;
        tick();
        test_reset();
        test_jumps();
        test_trap();
        test_halt();
        test_branch_at_halt_pc();
        test_stall();
        test_wrap();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V core.
- Holds the architectural PC register and selects the next PC: sequential, PC-relative jump, register-relative jump, or conditional branch.
- Adds behaviour the current combinational selector lacks: stall, a halt state, misaligned-target trap with exception PC capture and trap return, and a retired-instruction counter.
- Sits between decode/branch-compare and instruction memory; its pc output drives the instruction fetch address.

Parameters:
- XLEN, 32, width of PC and all address/data operands.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_EN, 1, 1 = enable the halt-address detection.
- HALT_PC, 32'h0000_006c, sequential fetch from this PC enters HALT.
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned-target trap.
- C_EXT, 0, 1 = 2-byte instruction alignment; 0 = 4-byte alignment.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC, state and counter this cycle.
- sel  in  2  00 sequential/branch, 01 pc+offset (jal), 10 rs1+offset (jalr), 11 reserved (treated as 00).
- branch_taken  in  1  conditional branch resolved taken.
- trap_ret  in  1  return from trap (mret-like).
- offset  in  XLEN  sign-extended immediate.
- rs1_data  in  XLEN  rs1 register value.
- pc  out  XLEN  current PC (registered).
- next_pc  out  XLEN  value pc takes at the next non-stalled edge (combinational).
- epc  out  XLEN  PC of the instruction that trapped (registered).
- trap  out  1  registered one-cycle pulse: a trap was taken on the previous edge.
- halted  out  1  unit is in HALT.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, epc=0, trap=0, halted=0, instret=0, state=RUN.
- States: RUN, HALT.
- RUN to HALT: HALT_EN=1, pc==HALT_PC, the target is sequential, and stall=0.
- HALT is exited only by rst. In HALT: pc holds, next_pc=pc, instret frozen, trap_ret ignored.
- Target priority in RUN, highest first:
  1. trap_ret: target=epc.
  2. sel=01: target=pc+offset.
  3. sel=10: target=(rs1_data+offset) with bit0 cleared.
  4. branch_taken: target=pc+offset.
  5. Otherwise sequential: target=pc+4.
- Halt check applies only in case 5. On entering HALT, pc keeps HALT_PC.
- Arithmetic is modulo 2^XLEN; pc+4 at 32'hFFFF_FFFC wraps to 0.
- Misaligned target: C_EXT=0 and target[1]=1. (Bit0 is always 0 for legal paths. With C_EXT=1 no trap is possible.)
- On a misaligned target: pc<=TRAP_VEC, epc<=pc, trap=1 for the next cycle, instret not incremented. A misaligned trap_ret target also traps; epc is overwritten.
- Trap check applies to redirect targets only. The sequential path is always aligned once pc is aligned.
- stall=1: pc, epc, state and instret hold; trap drives 0. next_pc still shows the target that would be taken.
- instret increments by 1 on every RUN, non-stalled, non-trapping edge, including trap_ret. It wraps at 2^CNT_W.
- Reset mid-operation (stalled, halted, or in the trap cycle) wins unconditionally.
- Latency: a redirect presented in cycle N appears on pc after edge N+1; there are no bubbles.

Decomposition:
- Shared package holds the sel encoding constants (SEL_SEQ, SEL_JAL, SEL_JALR) and the state enum (RUN, HALT).
- No sub-module. The target mux and alignment check stay as one combinational block inside pc_unit.

Test Plan:
- Reset then 3 free-run cycles -> pc 0,4,8,12; instret=3; trap=0.
- pc=0x20, sel=01, offset=0x40 -> pc=0x60 next cycle. Then sel=10, rs1_data=0x101, offset=0 -> pc=0x100.
- pc=0x10, sel=01, offset=0x6 (target 0x16) -> pc=0x100 (TRAP_VEC), epc=0x10, trap pulses one cycle, instret unchanged. Then trap_ret=1 -> pc=0x10.
- Run sequentially to pc=0x6c -> halted=1, pc stays 0x6c for 10 cycles, instret frozen. Then rst -> pc=0, halted=0.
- pc=0x6c with branch_taken=1, offset=-8 -> pc=0x64, no halt. Same cycle with stall=1 -> pc holds 0x6c, next_pc=0x64.
- Stall asserted 4 cycles at pc=0x8 -> pc and instret unchanged. rst asserted during stall -> pc=RESET_PC next edge.
